// File: rtl/rt_task_dispatcher_pkg.sv
// rtl/rt_task_dispatcher_pkg.sv - shared types and defaults for the task dispatcher and scheduler
package rt_pkg;

  localparam int RT_NUM_TASKS       = 16;
  localparam int RT_ID_W            = 8;
  localparam int RT_MIN_RUN_DEFAULT = 4;

  typedef logic [RT_ID_W-1:0] task_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } rt_state_e;

endpackage

// File: rtl/rt_task_dispatcher_holdoff_counter.sv
// rtl/rt_task_dispatcher_holdoff_counter.sv - saturating run-time counter gating preemption
module dispatch_holdoff_counter #(
  parameter int MIN_RUN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int W = (MIN_RUN < 1) ? 1 : $clog2(MIN_RUN + 1);
  localparam logic [W-1:0] LIMIT = W'(MIN_RUN);

  logic [W-1:0] run_ticks_q;
  logic [W-1:0] run_ticks_d;

  // Clear wins over tick so a fresh task always starts from zero.
  always_comb begin
    run_ticks_d = run_ticks_q;
    if (clr) begin
      run_ticks_d = '0;
    end else if (tick && (run_ticks_q < LIMIT)) begin
      run_ticks_d = run_ticks_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_ticks_q <= '0;
    end else begin
      run_ticks_q <= run_ticks_d;
    end
  end

  assign expired = (run_ticks_q >= LIMIT);

endmodule

// File: rtl/rt_task_dispatcher.sv
// rtl/rt_task_dispatcher.sv - turns scheduler decisions into save/load context switches and CPU gating
module rt_task_dispatcher
  import rt_pkg::*;
#(
  parameter int NUM_TASKS = RT_NUM_TASKS,
  parameter int ID_W      = RT_ID_W,
  parameter int MIN_RUN   = RT_MIN_RUN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] scheduled_task,
  input  logic            schedule_valid,
  input  logic            timer_tick,
  input  logic            cpu_task_done,
  output logic            ctx_save_req,
  output logic [3:0]      ctx_save_id,
  input  logic            ctx_save_ack,
  output logic            ctx_load_req,
  output logic [3:0]      ctx_load_id,
  input  logic            ctx_load_ack,
  output logic            cpu_halt,
  output logic [ID_W-1:0] running_task,
  output logic            running_valid,
  output logic            task_complete,
  output logic [ID_W-1:0] complete_id,
  output logic            switch_busy,
  output logic [15:0]     preempt_count
);

  localparam logic [ID_W-1:0] NUM_TASKS_ID = ID_W'(NUM_TASKS);

  rt_state_e       state_q, state_d;
  logic [ID_W-1:0] next_id_q, next_id_d;
  logic [ID_W-1:0] running_task_q, running_task_d;
  logic [ID_W-1:0] complete_id_q, complete_id_d;
  logic            running_valid_q, running_valid_d;
  logic            task_complete_q, task_complete_d;
  logic            cpu_halt_q, cpu_halt_d;
  logic            switch_busy_q, switch_busy_d;
  logic            ctx_save_req_q, ctx_save_req_d;
  logic            ctx_load_req_q, ctx_load_req_d;
  logic [3:0]      ctx_save_id_q, ctx_save_id_d;
  logic [3:0]      ctx_load_id_q, ctx_load_id_d;
  logic [15:0]     preempt_count_q, preempt_count_d;

  logic id_ok;
  logic hold_clr;
  logic hold_tick;
  logic hold_expired;

  assign id_ok     = schedule_valid && (scheduled_task < NUM_TASKS_ID);
  assign hold_tick = timer_tick && (state_q == ST_RUN);

  dispatch_holdoff_counter #(
    .MIN_RUN (MIN_RUN)
  ) u_holdoff (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (hold_clr),
    .tick    (hold_tick),
    .expired (hold_expired)
  );

  always_comb begin
    state_d         = state_q;
    next_id_d       = next_id_q;
    running_task_d  = running_task_q;
    running_valid_d = running_valid_q;
    complete_id_d   = complete_id_q;
    task_complete_d = 1'b0;
    preempt_count_d = preempt_count_q;
    ctx_save_id_d   = ctx_save_id_q;
    ctx_load_id_d   = ctx_load_id_q;
    hold_clr        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (id_ok) begin
          next_id_d     = scheduled_task;
          ctx_load_id_d = scheduled_task[3:0];
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ctx_load_ack) begin
          running_task_d  = next_id_q;
          running_valid_d = 1'b1;
          hold_clr        = 1'b1;
          state_d         = ST_RUN;
        end
      end
      // Task exit outranks preemption: a finished task has no context worth saving.
      ST_RUN: begin
        if (cpu_task_done) begin
          task_complete_d = 1'b1;
          complete_id_d   = running_task_q;
          running_valid_d = 1'b0;
          state_d         = ST_IDLE;
        end else if (id_ok && (scheduled_task != running_task_q) && hold_expired) begin
          next_id_d     = scheduled_task;
          ctx_save_id_d = running_task_q[3:0];
          if (preempt_count_q != 16'hFFFF) begin
            preempt_count_d = preempt_count_q + 16'd1;
          end
          state_d = ST_SAVE;
        end
      end
      ST_SAVE: begin
        if (ctx_save_ack) begin
          running_valid_d = 1'b0;
          ctx_load_id_d   = next_id_q[3:0];
          state_d         = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_halt_d     = (state_d != ST_RUN);
    switch_busy_d  = (state_d == ST_SAVE) || (state_d == ST_LOAD);
    ctx_save_req_d = (state_d == ST_SAVE);
    ctx_load_req_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      next_id_q       <= '0;
      running_task_q  <= '0;
      running_valid_q <= 1'b0;
      complete_id_q   <= '0;
      task_complete_q <= 1'b0;
      cpu_halt_q      <= 1'b1;
      switch_busy_q   <= 1'b0;
      ctx_save_req_q  <= 1'b0;
      ctx_load_req_q  <= 1'b0;
      ctx_save_id_q   <= '0;
      ctx_load_id_q   <= '0;
      preempt_count_q <= '0;
    end else begin
      state_q         <= state_d;
      next_id_q       <= next_id_d;
      running_task_q  <= running_task_d;
      running_valid_q <= running_valid_d;
      complete_id_q   <= complete_id_d;
      task_complete_q <= task_complete_d;
      cpu_halt_q      <= cpu_halt_d;
      switch_busy_q   <= switch_busy_d;
      ctx_save_req_q  <= ctx_save_req_d;
      ctx_load_req_q  <= ctx_load_req_d;
      ctx_save_id_q   <= ctx_save_id_d;
      ctx_load_id_q   <= ctx_load_id_d;
      preempt_count_q <= preempt_count_d;
    end
  end

  assign ctx_save_req  = ctx_save_req_q;
  assign ctx_save_id   = ctx_save_id_q;
  assign ctx_load_req  = ctx_load_req_q;
  assign ctx_load_id   = ctx_load_id_q;
  assign cpu_halt      = cpu_halt_q;
  assign running_task  = running_task_q;
  assign running_valid = running_valid_q;
  assign task_complete = task_complete_q;
  assign complete_id   = complete_id_q;
  assign switch_busy   = switch_busy_q;
  assign preempt_count = preempt_count_q;

endmodule

// File: doc/rt_task_dispatcher.md
# rt_task_dispatcher

Downstream stage of the real-time scheduler: consumes `scheduled_task`/`schedule_valid` and turns scheduling decisions into CPU context switches. Sequences save-context and load-context handshakes with the register-file/context-store unit, gates the CPU via `cpu_halt`, and enforces a minimum run time so the CPU does not thrash between tasks. Reports task completion back to the scheduler with `task_complete`/`complete_id`.

## Interface
- `NUM_TASKS`, 16: valid task IDs are 0..NUM_TASKS-1; other IDs are ignored.
- `ID_W`, 8: task ID width; matches the scheduler.
- `MIN_RUN`, 4: timer ticks a task must run before it can be preempted; 0 means preemption is immediate.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `scheduled_task` in ID_W: task chosen by the scheduler.
- `schedule_valid` in 1: `scheduled_task` is meaningful.
- `timer_tick` in 1: one-cycle tick, shared with the scheduler.
- `cpu_task_done` in 1: the running task has exited (one-cycle pulse).
- `ctx_save_req` out 1, `ctx_save_id` out 4, `ctx_save_ack` in 1: context-save handshake.
- `ctx_load_req` out 1, `ctx_load_id` out 4, `ctx_load_ack` in 1: context-load handshake.
- `cpu_halt` out 1: CPU stalled; low only in RUN.
- `running_task` out ID_W, `running_valid` out 1: task currently owning the CPU.
- `task_complete` out 1, `complete_id` out ID_W: one-cycle completion pulse to the scheduler.
- `switch_busy` out 1: high in SAVE or LOAD.
- `preempt_count` out 16: count of preemptions, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, SAVE, LOAD, RUN.
- **IDLE**: no task owns the CPU; `cpu_halt`=1. On sampling `schedule_valid` with `scheduled_task` < NUM_TASKS, latch `next_id` and go to LOAD. No save is needed.
- **LOAD**: `ctx_load_req`=1 with `ctx_load_id`=`next_id[3:0]`, held until `ctx_load_ack` is sampled high. On the ack edge: go to RUN, set `running_task`=`next_id`, set `running_valid`=1, clear `run_ticks`.
- **RUN**: `cpu_halt`=0. `run_ticks` increments on `timer_tick` and saturates at MIN_RUN. Priority of events, highest first:
  1. `cpu_task_done`: pulse `task_complete` with `complete_id`=`running_task`, clear `running_valid`, go to IDLE. No save.
  2. Preemption: `schedule_valid`, `scheduled_task` differs from `running_task`, `scheduled_task` < NUM_TASKS, and `run_ticks` ≥ MIN_RUN. Latch `next_id`, increment `preempt_count` (saturating), go to SAVE.
  3. Otherwise stay in RUN.
- **SAVE**: `ctx_save_req`=1 with `ctx_save_id`=`running_task[3:0]` until `ctx_save_ack` is sampled high. On ack: clear `running_valid`, go to LOAD with the latched `next_id`.
- Scheduler changes during SAVE or LOAD are ignored. They are re-evaluated in RUN, subject to MIN_RUN.
- `cpu_task_done` outside RUN is ignored. `timer_tick` outside RUN does not change `run_ticks`.
- An ack arriving without the matching request is ignored.

## Timing
- Every output is registered.
- Reset values (asynchronous): state IDLE, `cpu_halt`=1, and all other outputs 0, including `preempt_count`, `run_ticks` and `next_id`.
- Requests are level signals. A request rises the cycle after the state is entered and falls the cycle after its ack is sampled. A request is never high while its ack is being ignored.
- Minimum latency from IDLE (ack returned in the same cycle as the request):
  - Edge 0: IDLE samples valid.
  - Edge 1: `ctx_load_req` high, ack sampled.
  - Edge 2: RUN, `cpu_halt`=0.
- Preemption with zero-wait acks: 4 edges from the preempt decision to the new task running (RUN→SAVE→LOAD→RUN).
- `task_complete` is high for exactly one cycle, on the cycle after the edge that samples `cpu_task_done`.
- Reset asserted mid-SAVE or mid-LOAD: requests drop immediately and the in-flight context is abandoned.
- `preempt_count` holds at 16'hFFFF once saturated.

## Structure
- Shared package `rt_pkg` holds:
  - the FSM state enum (IDLE, SAVE, LOAD, RUN);
  - `RT_NUM_TASKS`, `RT_ID_W`, `RT_MIN_RUN_DEFAULT`;
  - a task-ID typedef shared with the scheduler.
- One sub-module: `dispatch_holdoff_counter`, the saturating `run_ticks` counter with clear, tick and `expired` (`run_ticks` ≥ MIN_RUN) output.
- The FSM, handshakes and output registers stay in the top module.

## Test plan
- **Cold start**: after reset, `schedule_valid`=1 with task 3 and `ctx_load_ack` tied high → `ctx_load_id`=3, `cpu_halt` low 2 cycles later, `running_task`=3, `ctx_save_req` never asserted.
- **Preemption gated by MIN_RUN=4**: task 3 running, scheduler switches to task 5 → no SAVE until 4 ticks have elapsed. Then save id 3 followed by load id 5, and `preempt_count`=1.
- **Completion racing preemption**: `cpu_task_done` and a different `scheduled_task` arrive in the same cycle → `task_complete` pulse with `complete_id`=3, no save, state IDLE, `preempt_count` unchanged.
- **Slow ack**: `ctx_save_ack` delayed 6 cycles → `ctx_save_req` held stable for all 6 cycles, `switch_busy`=1, `cpu_halt`=1, and a scheduler change to task 7 mid-save does not alter the load of task 5.
- **Invalid ID and async reset**: `scheduled_task`=20 is ignored (state stays IDLE). `rst_n` pulsed low mid-LOAD → `ctx_load_req` drops with no clock edge, outputs return to reset values.
